opti_sos_engine: RTL and testbench

Time-multiplexed two-section biquad (SOS) cascade datapath for the IIR filter. Accepts one Q1.15 sample at a time and runs it through SOS section 0 then section 1 in Direct Form I using a single multiplier-accumulator. Drives the section select of the coefficient ROM and consumes its five Q2.14 coefficients. Emits one Q1.15 filtered sample per accepted input.

---
 rtl/opti_sos_engine.sv | 193 +++++++++++++++++++
 tb/tb_opti_sos_engine.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opti_sos_engine.sv
// opti_sos_engine: two-section DF-I biquad cascade on one shared MAC.
// Ports: clk, rst_n (sync, active-low), in_valid/in_data/in_ready sample
// input, coef_stage + coef_b0..coef_a2 ROM link, out_valid/out_data result,
// sat_flag. Build macro OPTI_SAT_EN: clamp section results, sticky sat_flag.
module opti_sos_engine #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int FRAC = 14,
  parameter int ACCW = 36
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          coef_stage,
  input  logic [CW-1:0] coef_b0,
  input  logic [CW-1:0] coef_b1,
  input  logic [CW-1:0] coef_b2,
  input  logic [CW-1:0] coef_a1,
  input  logic [CW-1:0] coef_a2,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          sat_flag
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_WR
  } state_t;

  localparam logic signed [ACCW-1:0] HALF =
    ACCW'(1) <<< (FRAC - 1);

  state_t                 state;
  logic [2:0]             tap;
  logic signed [ACCW-1:0] acc;
  logic signed [DW-1:0]   x_cur;
  logic signed [DW-1:0]   x1 [2];
  logic signed [DW-1:0]   x2 [2];
  logic signed [DW-1:0]   y1 [2];
  logic signed [DW-1:0]   y2 [2];

  logic signed [DW-1:0]      opa;
  logic signed [CW-1:0]      coef;
  logic                      sub;
  logic signed [DW+CW-1:0]   prod;
  logic signed [ACCW-1:0]    prod_ext;
  logic signed [ACCW-1:0]    acc_nxt;
  logic signed [ACCW-1:0]    rsum;
  logic signed [ACCW-1:0]    rsh;
  logic signed [DW-1:0]      r;

  assign in_ready = (state == S_IDLE);

  // Tap order: b0*x, b1*x1, b2*x2, a1*y1, a2*y2 (a-terms subtracted).
  always_comb begin
    opa  = x_cur;
    coef = $signed(coef_b0);
    sub  = 1'b0;
    unique case (tap)
      3'd0: begin
        opa  = x_cur;
        coef = $signed(coef_b0);
      end
      3'd1: begin
        opa  = x1[coef_stage];
        coef = $signed(coef_b1);
      end
      3'd2: begin
        opa  = x2[coef_stage];
        coef = $signed(coef_b2);
      end
      3'd3: begin
        opa  = y1[coef_stage];
        coef = $signed(coef_a1);
        sub  = 1'b1;
      end
      3'd4: begin
        opa  = y2[coef_stage];
        coef = $signed(coef_a2);
        sub  = 1'b1;
      end
      default: begin
        opa  = x_cur;
        coef = $signed(coef_b0);
        sub  = 1'b0;
      end
    endcase
  end

  assign prod     = opa * coef;
  assign prod_ext = ACCW'(prod);
  assign acc_nxt  = sub ? acc - prod_ext : acc + prod_ext;

  // Round half up, then drop the fractional bits.
  assign rsum = acc + HALF;
  assign rsh  = rsum >>> FRAC;

`ifdef OPTI_SAT_EN
  localparam logic signed [ACCW-1:0] MAX_V =
    (ACCW'(1) <<< (DW - 1)) - ACCW'(1);
  localparam logic signed [ACCW-1:0] MIN_V = ~MAX_V;

  logic clip;

  always_comb begin
    r    = rsh[DW-1:0];
    clip = 1'b0;
    if (rsh > MAX_V) begin
      r    = MAX_V[DW-1:0];
      clip = 1'b1;
    end else if (rsh < MIN_V) begin
      r    = MIN_V[DW-1:0];
      clip = 1'b1;
    end
  end
`else
  logic unused_hi;

  // Wrap: only the low DW bits survive.
  assign r         = rsh[DW-1:0];
  assign unused_hi = ^rsh[ACCW-1:DW];
  assign sat_flag  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tap        <= '0;
      acc        <= '0;
      x_cur      <= '0;
      coef_stage <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      for (int i = 0; i < 2; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
`ifdef OPTI_SAT_EN
      sat_flag   <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_cur      <= in_data;
            acc        <= '0;
            tap        <= '0;
            coef_stage <= 1'b0;
            state      <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc_nxt;
          if (tap == 3'd4) begin
            state <= S_WR;
          end else begin
            tap <= tap + 3'd1;
          end
        end
        S_WR: begin
          x2[coef_stage] <= x1[coef_stage];
          x1[coef_stage] <= x_cur;
          y2[coef_stage] <= y1[coef_stage];
          y1[coef_stage] <= r;
`ifdef OPTI_SAT_EN
          sat_flag <= sat_flag | clip;
`endif
          if (!coef_stage) begin
            // Section 0 result feeds section 1.
            x_cur      <= r;
            coef_stage <= 1'b1;
            acc        <= '0;
            tap        <= '0;
            state      <= S_MAC;
          end else begin
            out_data   <= r;
            out_valid  <= 1'b1;
            coef_stage <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opti_sos_engine.sv
// tb_opti_sos_engine: self-checking bench for opti_sos_engine.
// Table vectors, hand sequences and random samples vs. arithmetic model.
module tb_opti_sos_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        coef_stage;
  logic [15:0] coef_b0, coef_b1, coef_b2, coef_a1, coef_a2;
  logic        out_valid;
  logic [15:0] out_data;
  logic        sat_flag;

  logic [15:0] rom [2][5];

  always #5 clk = ~clk;

  assign coef_b0 = rom[coef_stage][0];
  assign coef_b1 = rom[coef_stage][1];
  assign coef_b2 = rom[coef_stage][2];
  assign coef_a1 = rom[coef_stage][3];
  assign coef_a2 = rom[coef_stage][4];

  opti_sos_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .coef_stage (coef_stage),
    .coef_b0    (coef_b0),
    .coef_b1    (coef_b1),
    .coef_b2    (coef_b2),
    .coef_a1    (coef_a1),
    .coef_a2    (coef_a2),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .sat_flag   (sat_flag)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint mx1 [2], mx2 [2], my1 [2], my2 [2];
  bit     msat;

  function automatic longint cf(input int s, input int k);
    return longint'($signed(rom[s][k]));
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
    end
    msat = 1'b0;
  endtask

  task automatic model_step(input logic [15:0] din,
                            output logic [15:0] dout);
    longint x, acc, r;
    x = longint'($signed(din));
    for (int s = 0; s < 2; s++) begin
      acc = cf(s, 0) * x + cf(s, 1) * mx1[s] + cf(s, 2) * mx2[s]
          - cf(s, 3) * my1[s] - cf(s, 4) * my2[s];
      r = (acc + 8192) >>> 14;
`ifdef OPTI_SAT_EN
      if (r > 32767) begin
        r = 32767; msat = 1'b1;
      end else if (r < -32768) begin
        r = -32768; msat = 1'b1;
      end
`else
      r = longint'($signed(r[15:0]));
`endif
      mx2[s] = mx1[s]; mx1[s] = x;
      my2[s] = my1[s]; my1[s] = r;
      x = r;
    end
    dout = x[15:0];
  endtask

  // ---------------- helpers ----------------
  task automatic set_prod();
    rom[0][0] = 16'h0A64; rom[0][1] = 16'h14C8; rom[0][2] = 16'h0A64;
    rom[0][3] = 16'hB6D9; rom[0][4] = 16'h1A6C;
    rom[1][0] = 16'h0A64; rom[1][1] = 16'h14C8; rom[1][2] = 16'h0A64;
    rom[1][3] = 16'hC000; rom[1][4] = 16'h1000;
  endtask

  task automatic set_sat();
    for (int k = 0; k < 5; k++) begin
      rom[0][k] = 16'h0000; rom[1][k] = 16'h0000;
    end
    rom[0][0] = 16'h7FFF;
    rom[1][0] = 16'h4000;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_sample(input logic [15:0] din,
                            output logic [15:0] dout,
                            output int lat, output bit ok);
    int guard = 0;
    while (!in_ready && guard < 30) begin
      @(posedge clk); #1; guard++;
    end
    in_valid = 1'b1;
    in_data  = din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    lat = 0; ok = 1'b0; dout = '0;
    while (!ok && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) begin
        ok = 1'b1; dout = out_data;
      end
    end
  endtask

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t tbl [$];

  initial begin
    logic [15:0] got, e;
    int          lat, cs_err, ov_err;
    bit          ok;

    // Vector table: 10 zero samples, then impulse tail.
    for (int i = 0; i < 10; i++) tbl.push_back('{16'h0000, 16'h0000, "zero"});
    set_prod();
    model_reset();
    model_step(16'h4000, e);
    for (int i = 0; i < 10; i++) begin
      model_step(16'h0000, e);
      tbl.push_back('{16'h0000, e, "imp_tail"});
    end

    // Reset state
    set_prod();
    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_coef_stage", 32'(coef_stage), 32'd0);
    check("rst_sat_flag", 32'(sat_flag), 32'd0);

    // Zero-input rows from reset
    for (int i = 0; i < 10; i++) begin
      run_sample(tbl[i].din, got, lat, ok);
      check({tbl[i].name, "_ok"}, 32'(ok), 32'd1);
      check(tbl[i].name, 32'(got), 32'(tbl[i].exp));
    end

    // Impulse with cycle-accurate coef_stage / latency tracking
    do_reset();
    in_valid = 1'b1; in_data = 16'h4000;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 16'h1234;
    cs_err = 0; ov_err = 0;
    for (int k = 0; k < 12; k++) begin
      if (coef_stage !== (k >= 6)) cs_err++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) ov_err++;
      @(posedge clk); #1;
    end
    check("imp_coef_stage_seq", 32'(cs_err), 32'd0);
    check("imp_busy_seq", 32'(ov_err), 32'd0);
    check("imp_out_valid_at_12", 32'(out_valid), 32'd1);
    check("imp_out_data", 32'(out_data), 32'h01B0);
    check("imp_in_ready_at_12", 32'(in_ready), 32'd1);
    check("imp_coef_stage_end", 32'(coef_stage), 32'd0);
    @(posedge clk); #1;
    check("imp_pulse_1cycle", 32'(out_valid), 32'd0);
    for (int i = 10; i < tbl.size(); i++) begin
      run_sample(tbl[i].din, got, lat, ok);
      check({tbl[i].name, "_lat"}, 32'(lat), 32'd12);
      check(tbl[i].name, 32'(got), 32'(tbl[i].exp));
    end

    // Handshake: in_valid held high, changing data
    begin
      logic [15:0] q [$];
      int accepts = 0, outs = 0, last_acc = -1, gap_err = 0;
      do_reset();
      in_valid = 1'b1;
      for (int cyc = 0; cyc < 90; cyc++) begin
        in_data = 16'($urandom_range(0, 16'h3FFF));
        if (in_valid && in_ready) begin
          model_step(in_data, e);
          q.push_back(e);
          if (last_acc >= 0 && cyc - last_acc != 13) gap_err++;
          last_acc = cyc;
          accepts++;
        end
        @(posedge clk); #1;
        if (out_valid) begin
          outs++;
          if (q.size() == 0) check("hs_spurious_out", 32'd1, 32'd0);
          else check("hs_out_data", 32'(out_data), 32'(q.pop_front()));
        end
        if (accepts == 4) in_valid = 1'b0;
      end
      check("hs_accepts", 32'(accepts), 32'd4);
      check("hs_gap", 32'(gap_err), 32'd0);
      check("hs_outs", 32'(outs), 32'd4);
    end

    // Saturation
    set_sat();
    do_reset();
    run_sample(16'h7FFF, got, lat, ok);
    model_step(16'h7FFF, e);
`ifdef OPTI_SAT_EN
    check("sat_out", 32'(got), 32'h7FFF);
    check("sat_flag", 32'(sat_flag), 32'd1);
`else
    check("wrap_out", 32'(got), 32'hFFFC);
    check("wrap_flag", 32'(sat_flag), 32'd0);
`endif
    run_sample(16'h0000, got, lat, ok);
    model_step(16'h0000, e);
    check("sat_model_out", 32'(got), 32'(e));
    check("sat_sticky", 32'(sat_flag), 32'(msat));

    // Reset mid-operation
    set_prod();
    do_reset();
    in_valid = 1'b1; in_data = 16'h4000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_coef_stage", 32'(coef_stage), 32'd0);
    ov_err = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) ov_err++;
      @(posedge clk); #1;
    end
    check("mid_rst_no_out", 32'(ov_err), 32'd0);
    model_reset();
    run_sample(16'h4000, got, lat, ok);
    check("mid_rst_rerun", 32'(got), 32'h01B0);
    check("mid_rst_rerun_lat", 32'(lat), 32'd12);

    // Random samples vs. model
    do_reset();
    for (int i = 0; i < 25; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      run_sample(d, got, lat, ok);
      model_step(d, e);
      check("rand_out", 32'(got), 32'(e));
    end
    check("rand_sat_flag", 32'(sat_flag), 32'(msat));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
